// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Handshake: start is a one-cycle request taken only while the block is idle (busy=0, done=0);
// a, b, sub and c_in are captured on that same edge. done pulses for one cycle when r/c_out are valid.
interface serial_add_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] r;
  logic             c_out;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, r, c_out
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, r, c_out
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full adder processes one operand bit per clock, LSB first.
// Results land on r/c_out only when the last bit is processed, so partial sums are never visible.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_sub_if.slave      bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_q;
  logic             c_out_q;
  logic             sum_bit, carry_nxt, last_bit;

  // Single full adder shared by every bit position.
  always_comb begin
    sum_bit   = x_sh[0] ^ y_sh[0] ^ carry;
    carry_nxt = (x_sh[0] & y_sh[0]) | (x_sh[0] & carry) | (y_sh[0] & carry);
    acc_nxt   = {sum_bit, acc[WIDTH-1:1]};
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = BUSY;
      BUSY:    if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_sh    <= '0;
      y_sh    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      r_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in high.
            x_sh  <= bus.a;
            y_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.c_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          x_sh  <= {1'b0, x_sh[WIDTH-1:1]};
          y_sh  <= {1'b0, y_sh[WIDTH-1:1]};
          acc   <= acc_nxt;
          carry <= carry_nxt;
          if (last_bit) begin
            r_q     <= acc_nxt;
            c_out_q <= carry_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == BUSY);
  assign bus.done  = (state == DONE);
  assign bus.r     = r_q;
  assign bus.c_out = c_out_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and exhaustive-shuffled bench for serial_add_sub at WIDTH=4 against a plain arithmetic model.
module tb_serial_add_sub;
  localparam int W = 4;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  logic [W:0] exp_q[$];
  logic [W-1:0] last_r;
  logic         last_c;

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic s, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input logic ci);
    int unsigned sum;
    int          diff;
    if (s) begin
      diff = int'(x) - int'(y);
      return {(x >= y), W'((diff + (1 << W)) % (1 << W))};
    end
    sum = int'(x) + int'(y) + int'(ci);
    return (W + 1)'(sum);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Presents an operation with start=1, steps the accept edge, and leaves start as-is.
  task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
    bus.sub   = s;
    bus.a     = x;
    bus.b     = y;
    bus.c_in  = ci;
    bus.start = 1'b1;
    exp_q.push_back(model(s, x, y, ci));
    @(posedge clk); #1;
    chk("accept_busy", 32'(bus.busy), 32'd1);
    chk("accept_done", 32'(bus.done), 32'd0);
  endtask

  // Runs the operation to completion, optionally scrambling operands while busy.
  task automatic complete(input bit scramble);
    int n;
    logic [W:0] e;
    n = 0;
    while (bus.busy === 1'b1 && n < 64) begin
      n++;
      chk("hold_r", 32'(bus.r), 32'(last_r));
      chk("hold_c", 32'(bus.c_out), 32'(last_c));
      if (scramble) begin
        bus.a    = W'($urandom_range(0, (1 << W) - 1));
        bus.b    = W'($urandom_range(0, (1 << W) - 1));
        bus.sub  = 1'($urandom_range(0, 1));
        bus.c_in = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    chk("busy_cycles", 32'(n), 32'(W));
    chk("done_pulse", 32'(bus.done), 32'd1);
    e = exp_q.pop_front();
    chk("result_r", 32'(bus.r), 32'(e[W-1:0]));
    chk("result_c", 32'(bus.c_out), 32'(e[W]));
    last_r = e[W-1:0];
    last_c = e[W];
    @(posedge clk); #1;
    chk("done_low", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("keep_r", 32'(bus.r), 32'(last_r));
  endtask

  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input bit scramble);
    launch(s, x, y, ci);
    bus.start = 1'b0;
    complete(scramble);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  int unsigned perm[1 << (2 * W + 2)];

  initial begin
    logic [2*W+1:0] v;
    int unsigned tmp;
    int j;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    last_r = '0;
    last_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_r", 32'(bus.r), 32'd0);
    chk("rst_c", 32'(bus.c_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic adds and subtracts, including wrap and borrow cases.
    do_op(1'b0, 4'd3,  4'd5,  1'b0, 1'b0);
    do_op(1'b0, 4'd15, 4'd1,  1'b0, 1'b0);
    do_op(1'b0, 4'd15, 4'd15, 1'b1, 1'b0);
    do_op(1'b1, 4'd7,  4'd3,  1'b0, 1'b0);
    do_op(1'b1, 4'd3,  4'd7,  1'b0, 1'b0);
    do_op(1'b1, 4'd9,  4'd9,  1'b0, 1'b0);
    do_op(1'b1, 4'd5,  4'd2,  1'b1, 1'b0);

    // start held high, operands churning during BUSY; next op accepted only after IDLE.
    launch(1'b0, 4'd6, 4'd5, 1'b1);
    complete(1'b1);
    launch(1'b1, 4'd10, 4'd3, 1'b0);
    bus.start = 1'b0;
    complete(1'b0);

    // Reset two edges into an operation aborts it without a done pulse.
    launch(1'b0, 4'd9, 4'd6, 1'b0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_r", 32'(bus.r), 32'd0);
    chk("abort_c", 32'(bus.c_out), 32'd0);
    last_r = '0;
    last_c = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      chk("abort_no_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
    end
    do_op(1'b0, 4'd2, 4'd2, 1'b0, 1'b0);

    // Every operand/mode/carry combination in shuffled order.
    for (int i = 0; i < (1 << (2 * W + 2)); i++) perm[i] = i;
    for (int i = (1 << (2 * W + 2)) - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < (1 << (2 * W + 2)); i++) begin
      v = (2 * W + 2)'(perm[i]);
      do_op(v[2*W], v[W-1:0], v[2*W-1:W], v[2*W+1], 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1, mode select: 0 = add (a + b + c_in), 1 = subtract (a + ~b + 1); sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH, minuend/augend; sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH, subtrahend/addend; sampled with start.
REQ-008 The block SHALL have port c_in, input, 1, carry-in for add mode; sampled with start; ignored when sub=1.
REQ-009 The block SHALL have port busy, output, 1, high while bits are being processed.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking valid r/c_out.
REQ-011 The block SHALL have port r, output, WIDTH, sum/difference result.
REQ-012 The block SHALL have port c_out, output, 1, final carry (in sub mode, 1 = no borrow, a >= b unsigned).

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE -> BUSY SHALL occur on a rising edge with start=1; at that edge a, b (inverted if sub=1), and carry (c_in, or 1 if sub=1) SHALL be captured into internal shift and carry registers, and a bit counter SHALL be cleared to 0.
REQ-015 In BUSY, each rising edge SHALL process exactly one bit, LSB first, via one 1-bit full adder: sum = x ^ y ^ c, carry = majority(x, y, c); sum shifted into an internal result register, carry stored for the next bit.
REQ-016 BUSY -> DONE SHALL occur on the edge processing bit WIDTH-1 (counter = WIDTH-1); at that edge r SHALL load the full internal result and c_out the final carry.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next edge.
REQ-018 busy SHALL equal (state == BUSY); done SHALL equal (state == DONE).
REQ-019 Latency: with start sampled at edge 0, done SHALL be high during the cycle after edge WIDTH (WIDTH+1 cycles from start to done-deassert edge); throughput is one operation per WIDTH+2 cycles.
REQ-020 r and c_out SHALL change only at the BUSY -> DONE edge and SHALL hold their value until the next completion or reset; partial results SHALL never appear on r.
REQ-021 start SHALL be ignored in BUSY and DONE; changes to a, b, sub, c_in after the start edge SHALL have no effect on the running operation.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; overflow is reported only via c_out; no signed-overflow flag.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap within an operation.

Reset
REQ-024 When rst=1 at a rising edge, state SHALL go to IDLE, and busy, done, r, c_out, counter, and internal registers SHALL go to 0, regardless of state or start.
REQ-025 rst SHALL take priority over start on the same edge; reset mid-BUSY SHALL abort the operation with no done pulse.
REQ-026 The first start accepted after rst deasserts SHALL behave identically to one from power-up.

Verification (WIDTH=4)
REQ-027 add, a=3, b=5, c_in=0, start at edge 0 -> busy high for cycles 1..4, done pulse in cycle 5, r=8, c_out=0.
REQ-028 add, a=15, b=1, c_in=0 -> r=0, c_out=1; then a=15, b=15, c_in=1 -> r=15, c_out=1.
REQ-029 sub, a=7, b=3 (c_in=0 ignored) -> r=4, c_out=1; sub, a=3, b=7 -> r=12, c_out=0; sub, a=b=9 -> r=0, c_out=1.
REQ-030 start held high continuously, operands changed every cycle during BUSY -> only the first start accepted, result matches operands captured at the start edge; the next operation starts in IDLE after done.
REQ-031 rst asserted at edge 2 of an operation -> busy, done, r, c_out all 0 next cycle; no done pulse; subsequent add 2+2 -> r=4.
REQ-032 Random regression over all 2^(2*4+2) operand/mode/carry combinations -> r and c_out match the reference model (a + b + c_in) or (a - b) mod 16 with the stated carry rule.
